// File: rtl/dmadd_sequencer.sv
// Batch sequencer for a downstream delta-MADD unit: buffers load words in a FIFO,
// then steps INIT -> LOAD -> RUN -> CAPTURE for each start request.
module dmadd_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int RUN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic [3:0]  index,
  output logic [3:0]  data,
  output logic [1:0]  insn,
  output logic        load,
  output logic        run,
  input  logic [11:0] dmadd_out,
  output logic [11:0] result,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0]       INSN_HOLD = 2'b11;
  localparam logic [1:0]       MODE_BAD  = 2'b11;
  localparam logic [1:0]       MODE_MADD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE
  } state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      result_q;
  logic             err_q;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic [8:0]       head;

  // Gating with rst_n keeps the buffer closed during the reset cycle itself.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_LOAD) && !empty;
  assign head     = mem_q[rd_ptr_q];

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_BAD) begin
              err_q <= 1'b1;
            end else begin
              mode_q  <= mode;
              state_q <= ST_INIT;
            end
          end
        end
        ST_INIT: state_q <= ST_LOAD;
        ST_LOAD: begin
          if (pop && head[8]) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_LAST) state_q <= ST_CAPTURE;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        ST_CAPTURE: begin
          result_q <= dmadd_out;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Downstream controls decode from state; LOAD shows the word being popped this cycle.
  always_comb begin
    insn  = INSN_HOLD;
    load  = 1'b0;
    run   = 1'b0;
    index = 4'h0;
    data  = 4'h0;
    case (state_q)
      ST_INIT: insn = (mode_q == MODE_MADD) ? 2'b01 : mode_q;
      ST_LOAD: begin
        if (!empty) begin
          insn  = mode_q;
          load  = 1'b1;
          index = head[7:4];
          data  = head[3:0];
        end
      end
      ST_RUN: begin
        insn = mode_q;
        run  = 1'b1;
      end
      default: insn = INSN_HOLD;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_CAPTURE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Scoreboard bench for dmadd_sequencer: stimulus queues expected loads, modes and
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmadd_sequencer;

  localparam int DEPTH = 8;
  localparam int RUNC  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  index;
  logic [3:0]  data;
  logic [1:0]  insn;
  logic        load;
  logic        run;
  logic [11:0] dmadd_out = 12'h000;
  logic [11:0] result;
  logic        done;
  logic        busy;
  logic        err;

  dmadd_sequencer #(.FIFO_DEPTH(DEPTH), .RUN_CYCLES(RUNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .start     (start),
    .mode      (mode),
    .index     (index),
    .data      (data),
    .insn      (insn),
    .load      (load),
    .run       (run),
    .dmadd_out (dmadd_out),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Every pushed word is eventually loaded, in push order, unless a reset flushes it.
  logic [7:0]  exp_load_q [$];
  logic [1:0]  exp_mode_q [$];
  logic [11:0] exp_res_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit          prev_busy;
  bit          prev_run;
  int          run_len;
  logic [1:0]  cur_mode;
  logic [11:0] model_result;
  bit          cap_pending;
  logic [11:0] cap_val;
  logic [7:0]  mon_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy    = 1'b0;
      prev_run     = 1'b0;
      run_len      = 0;
      cap_pending  = 1'b0;
      model_result = 12'h000;
    end else begin
      if (cap_pending) begin
        model_result = cap_val;
        cap_pending  = 1'b0;
      end
      check("result_hold", result, model_result);
      if (!load) check("idx_data_zero", {index, data}, 8'h00);
      if (busy && !prev_busy) begin
        if (exp_mode_q.size() == 0) begin
          check("unexpected_init", busy, 0);
        end else begin
          cur_mode = exp_mode_q.pop_front();
          check("init_insn", insn, (cur_mode == 2'b10) ? 2'b01 : cur_mode);
          check("init_load_run", {load, run}, 2'b00);
        end
      end
      if (load) begin
        if (exp_load_q.size() == 0) begin
          check("unexpected_load", load, 0);
        end else begin
          mon_w = exp_load_q.pop_front();
          check("load_word", {index, data}, mon_w);
          check("load_insn", insn, cur_mode);
        end
      end
      if (run) begin
        run_len++;
        check("run_insn", {insn, load}, {cur_mode, 1'b0});
      end else if (prev_run) begin
        check("run_len", run_len, RUNC);
        run_len = 0;
      end
      if (done) begin
        check("capture_ctrl", {insn, load, run}, 4'b1100);
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          cap_val     = exp_res_q.pop_front();
          cap_pending = 1'b1;
        end
      end
      prev_busy = busy;
      prev_run  = run;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic arm_start(input logic [1:0] m, input logic [11:0] r);
    start     = 1'b1;
    mode      = m;
    dmadd_out = r;
    exp_mode_q.push_back(m);
    exp_res_q.push_back(r);
  endtask

  task automatic drive_word(input logic [7:0] w, input bit last, input bit with_start,
                            input logic [1:0] m, input logic [11:0] r);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    exp_load_q.push_back(w);
    if (with_start) arm_start(m, r);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
  endtask

  task automatic flush_model();
    exp_load_q.delete();
    exp_mode_q.delete();
    exp_res_q.delete();
  endtask

  task automatic random_batch();
    int          n;
    int          split;
    logic [1:0]  m;
    logic [11:0] r;
    logic [7:0]  w;
    n     = $urandom_range(1, 5);
    split = $urandom_range(0, n);
    m     = 2'($urandom_range(0, 2));
    r     = 12'($urandom_range(1, 4095));
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      drive_word(w, (i == n - 1), (i == split), m, r);
    end
    if (split == n) begin
      @(negedge clk);
      arm_start(m, r);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    int rc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_ctrl", {busy, done, err, load, run}, 5'b00000);
    check("rst_insn", insn, 2'b11);
    check("rst_idx_data", {index, data}, 8'h00);
    check("rst_result", result, 12'h000);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Two-word MIN batch
    drive_word(8'h31, 1'b0, 1'b0, 2'b00, 12'h000);
    drive_word(8'h52, 1'b1, 1'b1, 2'b00, 12'hA5C);
    wait_done();
    check("min_result", result, 12'hA5C);

    // MADD: INIT shows 01, LOAD/RUN show 10 (monitor)
    drive_word(8'h9E, 1'b1, 1'b1, 2'b10, 12'h3C7);
    wait_done();

    // Fill the buffer while idle
    for (int i = 0; i < DEPTH; i++)
      drive_word(8'(i * 17 + 3), (i == DEPTH - 1), 1'b0, 2'b00, 12'h000);
    check("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("full_ready_hold", in_ready, 0);
    arm_start(2'b01, 12'h5E1);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!load && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("full_first_load", load, 1);
    @(negedge clk);
    check("ready_after_pop", in_ready, 1);
    wait_done();

    // Start on an empty buffer; word arrives three cycles later
    arm_start(2'b00, 12'h7B2);
    @(negedge clk);
    start = 1'b0;
    check("empty_init_insn", insn, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_hold", {insn, load, busy}, 4'b1101);
    end
    in_valid = 1'b1;
    in_data  = 8'h74;
    in_last  = 1'b1;
    exp_load_q.push_back(8'h74);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("late_word_load", load, 1);
    @(negedge clk);
    check("late_word_run", run, 1);
    wait_done();

    // Illegal mode, then a start during RUN
    start = 1'b1;
    mode  = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("bad_mode_err", {err, busy}, 2'b10);
    @(negedge clk);
    check("bad_mode_err_clear", {err, busy}, 2'b00);
    drive_word(8'h6B, 1'b1, 1'b1, 2'b10, 12'h9D4);
    g = 0;
    while (!run && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("reach_run", run, 1);
    start = 1'b1;
    mode  = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("start_in_run_err", err, 0);
    wait_done();
    for (int i = 0; i < 3; i++) begin
      check("start_in_run_ignored", busy, 0);
      @(negedge clk);
    end

    // Reset on RUN cycle 5 with a word left buffered
    drive_word(8'h11, 1'b0, 1'b0, 2'b00, 12'h000);
    drive_word(8'h22, 1'b1, 1'b1, 2'b01, 12'h456);
    drive_word(8'h33, 1'b0, 1'b0, 2'b00, 12'h000);
    g  = 0;
    rc = 0;
    while (g < 200) begin
      if (run) rc++;
      if (rc == 5) break;
      @(negedge clk);
      g++;
    end
    check("run_cycle5_reached", rc, 5);
    rst_n = 1'b0;
    flush_model();
    @(negedge clk);
    check("mid_rst_ctrl", {run, busy, load, done, err}, 5'b00000);
    check("mid_rst_result", result, 12'h000);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_insn", insn, 2'b11);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    @(negedge clk);
    arm_start(2'b00, 12'h001);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fifo_empty_after_rst", {load, busy}, 2'b01);
    end
    rst_n = 1'b0;
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized batches
    for (int b = 0; b < 25; b++) random_batch();

    check("queues_drained", exp_load_q.size() + exp_mode_q.size() + exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmadd_sequencer.md
DMADD_SEQUENCER -- requirements
Module: dmadd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: entries in the input buffer (power of two, 2..16).
REQ-002 SHALL have parameter RUN_CYCLES, default 16: number of cycles the run phase is held.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream has a load word.
REQ-006 SHALL have port in_data  input  8  load word, {index[3:0], data[3:0]}.
REQ-007 SHALL have port in_last  input  1  marks the final word of a batch.
REQ-008 SHALL have port in_ready  output  1  buffer can accept a word this cycle.
REQ-009 SHALL have port start  input  1  single-cycle request to execute one batch.
REQ-010 SHALL have port mode  input  2  operation: 00 MIN, 01 MAX, 10 MADD, 11 illegal.
REQ-011 SHALL have ports index  output  4, data  output  4, insn  output  2, load  output  1, run  output  1: drive the downstream delta-MADD unit.
REQ-012 SHALL have port dmadd_out  input  12  result from the downstream unit.
REQ-013 SHALL have ports result  output  12, done  output  1, busy  output  1, err  output  1.

Function
REQ-014 SHALL store words {in_last, in_data} in a FIFO; a push occurs when in_valid && in_ready; in_ready = not full; pushes are accepted in every state.
REQ-015 SHALL implement states IDLE, INIT, LOAD, RUN, CAPTURE; busy = (state != IDLE).
REQ-016 IDLE: insn=11, load=0, run=0 (hold code); start with mode!=11 latches mode and moves to INIT next cycle; start with mode=11 stays IDLE and sets err for one cycle.
REQ-017 INIT (exactly one cycle): load=0, run=0, insn = 01 if latched mode is 10, else latched mode; next state LOAD.
REQ-018 LOAD: when FIFO non-empty, pop one word per cycle and drive load=1, insn=latched mode, index/data from the popped word in that same cycle; when empty, drive hold code (insn=11, load=0) and stall.
REQ-019 LOAD exits to RUN on the cycle after popping a word with in_last=1; words behind it stay buffered for the next batch.
REQ-020 RUN: run=1, load=0, insn=latched mode for exactly RUN_CYCLES cycles, counted by an internal counter cleared on entry; then CAPTURE.
REQ-021 CAPTURE (one cycle): hold code driven; result <= dmadd_out; done=1 for this cycle only; next state IDLE.
REQ-022 result SHALL hold its value until the next CAPTURE or reset.
REQ-023 start while busy SHALL be ignored (no queuing, no err).
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged; push when full cannot occur (in_ready=0); pointers wrap modulo FIFO_DEPTH.
REQ-025 index/data outputs SHALL be 0 whenever load=0.
REQ-026 A start in the same cycle as the last word arrives SHALL still process that word (INIT covers the one-cycle push latency).

Reset
REQ-027 rst_n=0 at a clock edge SHALL, in any state including mid-LOAD or mid-RUN: state=IDLE, FIFO empty, counter=0, result=0, done=0, err=0, busy=0, index=0, data=0, insn=11, load=0, run=0.
REQ-028 in_ready SHALL be 0 during the reset cycle and 1 from the first cycle with rst_n=1.

Verification
REQ-029 Push words 0x31 and 0x52(last), start mode=00 -> INIT insn=00 for 1 cycle; LOAD load=1 index=3 data=1, then index=5 data=2; run=1 for 16 cycles; done pulses once, result=dmadd_out.
REQ-030 start mode=10 -> INIT cycle drives insn=01; LOAD and RUN cycles drive insn=10.
REQ-031 Push 8 words without popping -> in_ready=0 after the 8th; 9th in_valid not accepted; after one pop in_ready=1 again.
REQ-032 start with FIFO empty, then push 0x74(last) 3 cycles later -> hold code for 3 LOAD cycles, then load=1 index=7 data=4, then RUN.
REQ-033 start mode=11 -> err=1 for one cycle, busy stays 0; start during RUN -> ignored.
REQ-034 Assert rst_n=0 on RUN cycle 5 -> next cycle run=0, busy=0, result=0, FIFO empty.
